sequence_transmitter: RTL and testbench

SEQUENCE_TRANSMITTER -- requirements
Module: sequence_transmitter

---
 rtl/sequence_transmitter.sv | 155 +++++++++++++++
 tb/tb_sequence_transmitter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_transmitter.sv
// Serial burst transmitter: sends a fixed PAT_W-bit pattern MSB first, repeat_cnt+1 times,
// with gap_cycles idle cycles between repetitions. Ends with a one-cycle done pulse; abort cancels.
module sequence_transmitter #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int unsigned      CNT_W   = 4,
    parameter int unsigned      GAP_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic             abort,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] REP_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_r,      state_s;
    logic [IDX_W-1:0] bit_idx_r,    bit_idx_s;
    logic [CNT_W-1:0] rep_r,        rep_s;
    logic [CNT_W-1:0] rep_lat_r,    rep_lat_s;
    logic [GAP_W-1:0] gap_lat_r,    gap_lat_s;
    logic [GAP_W-1:0] gap_cnt_r,    gap_cnt_s;
    logic             data_out_r,   data_out_s;
    logic             data_valid_r, data_valid_s;
    logic             done_r,       done_s;
    logic             busy_r,       busy_s;

    // Request handshake; held low while the block is in reset.
    always_comb begin
        start_ready = (state_r == IDLE) && !abort && reset;
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s      = state_r;
        bit_idx_s    = bit_idx_r;
        rep_s        = rep_r;
        rep_lat_s    = rep_lat_r;
        gap_lat_s    = gap_lat_r;
        gap_cnt_s    = gap_cnt_r;
        data_out_s   = 1'b0;
        data_valid_s = 1'b0;
        done_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (start_valid && start_ready) begin
                    state_s      = SEND;
                    bit_idx_s    = IDX_MSB;
                    rep_s        = REP_ZERO;
                    rep_lat_s    = repeat_cnt;
                    gap_lat_s    = gap_cycles;
                    data_out_s   = PATTERN[PAT_W-1];
                    data_valid_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (bit_idx_r != IDX_ZERO) begin
                    bit_idx_s    = bit_idx_r - IDX_ONE;
                    data_out_s   = PATTERN[bit_idx_s];
                    data_valid_s = 1'b1;
                end else if (rep_r == rep_lat_r) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    rep_s = rep_r + REP_ONE;
                    if (gap_lat_r == GAP_ZERO) begin
                        bit_idx_s    = IDX_MSB;
                        data_out_s   = PATTERN[PAT_W-1];
                        data_valid_s = 1'b1;
                    end else begin
                        state_s   = GAP;
                        gap_cnt_s = gap_lat_r - GAP_ONE;
                    end
                end
            end
            GAP: begin
                // gap_cnt_r counts the GAP cycles still to come after the current one.
                if (abort) begin
                    state_s = IDLE;
                end else if (gap_cnt_r == GAP_ZERO) begin
                    state_s      = SEND;
                    bit_idx_s    = IDX_MSB;
                    data_out_s   = PATTERN[PAT_W-1];
                    data_valid_s = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            bit_idx_r    <= IDX_ZERO;
            rep_r        <= REP_ZERO;
            rep_lat_r    <= REP_ZERO;
            gap_lat_r    <= GAP_ZERO;
            gap_cnt_r    <= GAP_ZERO;
            data_out_r   <= 1'b0;
            data_valid_r <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            bit_idx_r    <= bit_idx_s;
            rep_r        <= rep_s;
            rep_lat_r    <= rep_lat_s;
            gap_lat_r    <= gap_lat_s;
            gap_cnt_r    <= gap_cnt_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            done_r       <= done_s;
            busy_r       <= busy_s;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_sequence_transmitter.sv
// Table-driven bench for sequence_transmitter (default parameters, pattern 1101) plus
// hand-written sequences for reset mid-gap and the all-ones repeat count.
module tb_sequence_transmitter;

    logic       clk;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] repeat_cnt;
    logic [3:0] gap_cycles;
    logic       abort;
    logic       data_out;
    logic       data_valid;
    logic       busy;
    logic       done;

    int n_vec;
    int n_miss;

    sequence_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .repeat_cnt  (repeat_cnt),
        .gap_cycles  (gap_cycles),
        .abort       (abort),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {data_out, data_valid, busy, done, start_ready}.
    typedef struct {
        string      tag;
        logic       sv;
        logic       ab;
        logic [3:0] rc;
        logic [3:0] gc;
        logic [4:0] exp;
    } vec_t;

    vec_t  vq[$];
    string cur_tag;

    task automatic v(input logic sv, input logic ab, input logic [3:0] rc,
                     input logic [3:0] gc, input logic [4:0] e);
        vec_t r;
        r.tag = cur_tag; r.sv = sv; r.ab = ab; r.rc = rc; r.gc = gc; r.exp = e;
        vq.push_back(r);
    endtask

    // Four cycles of pattern 1101 while junk is driven on the config inputs.
    task automatic bits4();
        v(1'b0, 1'b0, 4'hA, 4'h5, 5'b11100);
        v(1'b0, 1'b0, 4'hA, 4'h5, 5'b11100);
        v(1'b0, 1'b0, 4'hA, 4'h5, 5'b01100);
        v(1'b0, 1'b0, 4'hA, 4'h5, 5'b11100);
    endtask

    task automatic gap3();
        for (int k = 0; k < 3; k++) v(1'b0, 1'b0, 4'h7, 4'h1, 5'b00100);
    endtask

    task automatic check(input string name, input logic [4:0] e);
        logic [4:0] got;
        got = {data_out, data_valid, busy, done, start_ready};
        n_vec++;
        if (got !== e) begin
            n_miss++;
            $display("FAIL %s: got {dout,valid,busy,done,ready}=%b expected %b", name, got, e);
        end
    endtask

    task automatic check_int(input string name, input int got, input int e);
        n_vec++;
        if (got != e) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, got, e);
        end
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        reset = 1'b0; start_valid = 1'b0; abort = 1'b0;
        repeat_cnt = 4'h0; gap_cycles = 4'h0;

        // --- vector tables ---
        cur_tag = "r0g0";
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b00001);
        bits4();
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00011);
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00001);

        cur_tag = "r1g0";
        v(1'b1, 1'b0, 4'h1, 4'h0, 5'b00001);
        bits4();
        bits4();
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00011);
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00001);

        cur_tag = "r2g3";
        v(1'b1, 1'b0, 4'h2, 4'h3, 5'b00001);
        bits4(); gap3(); bits4(); gap3(); bits4();
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00011);
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00001);

        cur_tag = "abort_send";
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b00001);
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b11100);
        v(1'b0, 1'b1, 4'h0, 4'h0, 5'b11100);
        v(1'b1, 1'b1, 4'h0, 4'h0, 5'b00000);
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b00001);
        bits4();
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00011);
        v(1'b0, 1'b1, 4'h0, 4'h0, 5'b00000);
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00001);

        cur_tag = "abort_gap";
        v(1'b1, 1'b0, 4'h1, 4'h2, 5'b00001);
        bits4();
        v(1'b0, 1'b1, 4'h0, 4'h0, 5'b00100);
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00001);
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00001);

        cur_tag = "back2back";
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b00001);
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b11100);
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b11100);
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b01100);
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b11100);
        v(1'b1, 1'b0, 4'h0, 4'h0, 5'b00011);
        bits4();
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00011);
        v(1'b0, 1'b0, 4'h0, 4'h0, 5'b00001);

        // --- reset state ---
        #1;
        check("reset_state", 5'b00000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("after_release", 5'b00001);

        // --- apply table ---
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            start_valid = vq[i].sv;
            abort       = vq[i].ab;
            repeat_cnt  = vq[i].rc;
            gap_cycles  = vq[i].gc;
            #1;
            check($sformatf("%s[%0d]", vq[i].tag, i), vq[i].exp);
        end

        // --- reset asserted mid-GAP ---
        @(negedge clk);
        start_valid = 1'b1; abort = 1'b0; repeat_cnt = 4'h1; gap_cycles = 4'h3;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("midgap_in_gap", 5'b00100);
        #1;
        reset = 1'b0;
        #1;
        check("midgap_async_reset", 5'b00000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midgap_released", 5'b00001);
        begin
            int stray;
            stray = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                #1;
                if (done || busy || data_valid) stray++;
            end
            check_int("midgap_no_done", stray, 0);
        end

        // --- repeat_cnt all ones: 16 reps, contiguous, done at cycle 65 ---
        begin
            logic [3:0] pat;
            int nbits, bad, done_cyc;
            pat = 4'b1101;
            nbits = 0; bad = 0; done_cyc = -1;
            @(negedge clk);
            start_valid = 1'b1; repeat_cnt = 4'hF; gap_cycles = 4'h0;
            @(negedge clk);
            start_valid = 1'b0;
            for (int k = 1; k <= 200; k++) begin
                #1;
                if (data_valid) begin
                    if (data_out !== pat[3 - (nbits % 4)] || k != nbits + 1) bad++;
                    nbits++;
                end
                if (done) begin
                    done_cyc = k;
                    break;
                end
                @(negedge clk);
            end
            check_int("allones_bits", nbits, 64);
            check_int("allones_bit_errors", bad, 0);
            check_int("allones_done_cycle", done_cyc, 65);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
